urv_dm_responder: RTL and testbench

//  Data-memory responder for the uRV core data port. Accepts load/store

---
 rtl/urv_dm_responder_pkg.sv | 24 ++
 rtl/urv_dm_responder_ram.sv | 41 ++++
 rtl/urv_dm_responder.sv | 133 +++++++++++++
 tb/tb_urv_dm_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/urv_dm_responder_pkg.sv
// Shared types and constants for the uRV data-memory responder.
`ifndef URV_DM_ERR_VALUE
`define URV_DM_ERR_VALUE 32'hdeadbeef
`endif

package urv_dm_responder_pkg;

  localparam int unsigned DM_WAIT_CNT_W = 4;
  localparam logic [31:0] DM_ERR_VALUE  = `URV_DM_ERR_VALUE;

  typedef enum logic [0:0] {
    DMR_IDLE = 1'b0,
    DMR_WAIT = 1'b1
  } dmr_state_e;

  // Request captured at accept time and replayed when the wait expires.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        store;
  } dm_req_t;

endpackage

// File: rtl/urv_dm_responder_ram.sv
// Single-port synchronous data RAM: byte-lane writes, read-before-write,
// one-cycle registered read that only updates on a load.
module urv_dm_responder_ram
  import urv_dm_responder_pkg::*;
#(
  parameter int unsigned g_addr_width = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [g_addr_width-1:0] addr_i,
  input  logic [31:0]             wdata_i,
  input  logic [3:0]              we_i,
  input  logic                    rd_i,
  input  logic                    rd_sub_i,
  output logic [31:0]             rdata_o
);

  localparam int unsigned DEPTH = 2 ** g_addr_width;

  logic [31:0] mem [DEPTH];

  // Byte-lane write port; array itself is not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read register holds the last load result; substitutes the error word
  // for loads that never reach the array.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (rd_i) begin
      rdata_o <= rd_sub_i ? DM_ERR_VALUE : mem[addr_i];
    end
  end

endmodule

// File: rtl/urv_dm_responder.sv
// uRV data-port responder: accepts load/store requests, applies
// g_wait_states busy cycles, serves them from a local byte-enable RAM.
// Optional URV_DM_BUS_ERR_EN: flag accesses outside the RAM window.
module urv_dm_responder
  import urv_dm_responder_pkg::*;
#(
  parameter int unsigned g_addr_width  = 12,
  parameter int unsigned g_wait_states = 0,
  parameter logic [31:0] g_base        = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_error_o
);

  dmr_state_e               state_q, state_d;
  logic [DM_WAIT_CNT_W-1:0] cnt_q, cnt_d;
  dm_req_t                  req_q;
  dm_req_t                  live_req;
  dm_req_t                  acc_req;
  logic                     accept;
  logic                     fire;
  logic                     in_win;
  logic                     ready_d;
  logic                     ld_done_d, st_done_d, err_d;
  logic [3:0]               ram_we;
  logic                     ram_rd;
  logic                     unused_bits;

  // A simultaneous load+store is treated as a store.
  assign live_req = '{addr: dm_addr_i, data: dm_data_s_i,
                      sel: dm_data_select_i, store: dm_store_i};

  assign accept = (state_q == DMR_IDLE) && (dm_load_i || dm_store_i);

  // Zero-wait accesses hit RAM at the accept edge; otherwise replay the latch.
  assign acc_req = (g_wait_states == 0) ? live_req : req_q;
  assign fire    = (g_wait_states == 0) ? accept
                 : ((state_q == DMR_WAIT) && (cnt_q == DM_WAIT_CNT_W'(1)));

  // Window decode against the RAM base.
`ifdef URV_DM_BUS_ERR_EN
  assign in_win      = (acc_req.addr[31:g_addr_width+2] == g_base[31:g_addr_width+2]);
  assign unused_bits = ^acc_req.addr[1:0];
`else
  assign in_win      = 1'b1;
  assign unused_bits = ^{acc_req.addr[1:0], acc_req.addr[31:g_addr_width+2], g_base};
`endif

  assign ram_we = (fire && acc_req.store && in_win) ? acc_req.sel : 4'b0000;
  assign ram_rd = fire && !acc_req.store;

  // Next-state, wait counter and completion pulses.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_done_d = fire && !acc_req.store;
    st_done_d = fire && acc_req.store;
    err_d     = fire && !in_win;
    case (state_q)
      DMR_IDLE: begin
        if (accept && (g_wait_states != 0)) begin
          state_d = DMR_WAIT;
          cnt_d   = DM_WAIT_CNT_W'(g_wait_states);
        end
      end
      DMR_WAIT: begin
        if (cnt_q == DM_WAIT_CNT_W'(1)) begin
          state_d = DMR_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - DM_WAIT_CNT_W'(1);
        end
      end
      default: begin
        state_d = DMR_IDLE;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == DMR_IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= DMR_IDLE;
      cnt_q           <= '0;
      dm_ready_o      <= 1'b1;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_error_o      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      dm_ready_o      <= ready_d;
      dm_load_done_o  <= ld_done_d;
      dm_store_done_o <= st_done_d;
      dm_error_o      <= err_d;
    end
  end

  // Request latch for wait-state replay.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q <= '0;
    end else if (accept) begin
      req_q <= live_req;
    end
  end

  urv_dm_responder_ram #(
    .g_addr_width(g_addr_width)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (acc_req.addr[g_addr_width+1:2]),
    .wdata_i (acc_req.data),
    .we_i    (ram_we),
    .rd_i    (ram_rd),
    .rd_sub_i(!in_win),
    .rdata_o (dm_data_l_o)
  );

endmodule

// File: tb/tb_urv_dm_responder.sv
// Directed bench: W=0 vector table plus W=3 / W=2 multi-cycle sequences.
module tb_urv_dm_responder;

  logic        clk;
  logic        rst   [3];
  logic [31:0] addr  [3];
  logic [31:0] wd    [3];
  logic [3:0]  sel   [3];
  logic        st    [3];
  logic        ld    [3];
  logic        rdy   [3];
  logic [31:0] rdata [3];
  logic        ldone [3];
  logic        sdone [3];
  logic        err   [3];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  urv_dm_responder #(.g_addr_width(12), .g_wait_states(0), .g_base(32'h0)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .dm_addr_i(addr[0]), .dm_data_s_i(wd[0]),
    .dm_data_select_i(sel[0]), .dm_store_i(st[0]), .dm_load_i(ld[0]),
    .dm_ready_o(rdy[0]), .dm_data_l_o(rdata[0]), .dm_load_done_o(ldone[0]),
    .dm_store_done_o(sdone[0]), .dm_error_o(err[0]));

  urv_dm_responder #(.g_addr_width(8), .g_wait_states(3), .g_base(32'h0)) u3 (
    .clk_i(clk), .rst_i(rst[1]), .dm_addr_i(addr[1]), .dm_data_s_i(wd[1]),
    .dm_data_select_i(sel[1]), .dm_store_i(st[1]), .dm_load_i(ld[1]),
    .dm_ready_o(rdy[1]), .dm_data_l_o(rdata[1]), .dm_load_done_o(ldone[1]),
    .dm_store_done_o(sdone[1]), .dm_error_o(err[1]));

  urv_dm_responder #(.g_addr_width(8), .g_wait_states(2), .g_base(32'h0)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .dm_addr_i(addr[2]), .dm_data_s_i(wd[2]),
    .dm_data_select_i(sel[2]), .dm_store_i(st[2]), .dm_load_i(ld[2]),
    .dm_ready_o(rdy[2]), .dm_data_l_o(rdata[2]), .dm_load_done_o(ldone[2]),
    .dm_store_done_o(sdone[2]), .dm_error_o(err[2]));

  typedef struct {
    bit          s;
    bit          l;
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  m;
    bit          e_ld;
    bit          e_st;
    bit          e_err;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 13;
  vec_t tv [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear(input int d);
    st[d] = 1'b0;
    ld[d] = 1'b0;
  endtask

  // Drive a request for one accept edge; returns #1 after that edge.
  task automatic issue(input int d, input bit s, input bit l, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] m);
    @(negedge clk);
    st[d] = s; ld[d] = l; addr[d] = a; wd[d] = w; sel[d] = m;
    @(posedge clk); #1;
  endtask

  // Called in cycle N+1; counts cycles until a done pulse and checks it.
  task automatic wait_done(input int d, input int lat, input bit e_ld, input bit e_st,
                           input bit e_err, input logic [31:0] e_data, input string nm);
    int c;
    @(negedge clk);
    clear(d);
    c = 1;
    while (!(ldone[d] || sdone[d]) && c <= 20) begin
      chk({nm, "_busy_ready"}, 32'(rdy[d]), 32'd0);
      @(posedge clk); #1;
      c++;
    end
    if (c > 20) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
    chk({nm, "_latency"}, 32'(c), 32'(lat + 1));
    chk({nm, "_load_done"}, 32'(ldone[d]), 32'(e_ld));
    chk({nm, "_store_done"}, 32'(sdone[d]), 32'(e_st));
    chk({nm, "_error"}, 32'(err[d]), 32'(e_err));
    chk({nm, "_data"}, rdata[d], e_data);
    chk({nm, "_ready"}, 32'(rdy[d]), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; addr[d] = '0; wd[d] = '0; sel[d] = '0; clear(d);
    end

    //             s  l  addr          wdata         sel    ld st er data
    tv[0]  = '{1, 0, 32'h10,   32'h11223344, 4'hF, 0, 1, 0, 32'h0};
    tv[1]  = '{0, 1, 32'h10,   32'h0,        4'hF, 1, 0, 0, 32'h11223344};
    tv[2]  = '{1, 0, 32'h10,   32'hAAAAAAAA, 4'h4, 0, 1, 0, 32'h11223344};
    tv[3]  = '{0, 1, 32'h10,   32'h0,        4'hF, 1, 0, 0, 32'h11AA3344};
    tv[4]  = '{1, 1, 32'h30,   32'h5,        4'hF, 0, 1, 0, 32'h11AA3344};
    tv[5]  = '{0, 1, 32'h30,   32'h0,        4'hF, 1, 0, 0, 32'h5};
    tv[6]  = '{1, 0, 32'h30,   32'hFFFFFFFF, 4'h0, 0, 1, 0, 32'h5};
    tv[7]  = '{0, 1, 32'h30,   32'h0,        4'hF, 1, 0, 0, 32'h5};
    tv[8]  = '{1, 0, 32'h33,   32'h12345678, 4'h3, 0, 1, 0, 32'h5};
    tv[9]  = '{0, 1, 32'h32,   32'h0,        4'hF, 1, 0, 0, 32'h00005678};
    tv[10] = '{0, 0, 32'h10,   32'h0,        4'hF, 0, 0, 0, 32'h00005678};
    tv[11] = '{1, 0, 32'h0,    32'hCAFEF00D, 4'hF, 0, 1, 0, 32'h00005678};
`ifdef URV_DM_BUS_ERR_EN
    tv[12] = '{0, 1, 32'h4000, 32'h0,        4'hF, 1, 0, 1, 32'hDEADBEEF};
`else
    tv[12] = '{0, 1, 32'h4000, 32'h0,        4'hF, 1, 0, 0, 32'hCAFEF00D};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d_ready", d), 32'(rdy[d]), 32'd1);
      chk($sformatf("rst%0d_data", d), rdata[d], 32'h0);
      chk($sformatf("rst%0d_pulses", d), 32'({ldone[d], sdone[d], err[d]}), 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // W=0 table: one request per cycle, results one cycle later
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      st[0] = tv[i].s; ld[0] = tv[i].l; addr[0] = tv[i].a;
      wd[0] = tv[i].w; sel[0] = tv[i].m;
      @(posedge clk); #1;
      chk($sformatf("v%0d_load_done", i), 32'(ldone[0]), 32'(tv[i].e_ld));
      chk($sformatf("v%0d_store_done", i), 32'(sdone[0]), 32'(tv[i].e_st));
      chk($sformatf("v%0d_error", i), 32'(err[0]), 32'(tv[i].e_err));
      chk($sformatf("v%0d_data", i), rdata[0], tv[i].e_data);
      chk($sformatf("v%0d_ready", i), 32'(rdy[0]), 32'd1);
    end
    @(negedge clk);
    clear(0);

    // W=3: store then load; load pulses during busy cycles are ignored
    issue(1, 1, 0, 32'h20, 32'h600DF00D, 4'hF);
    wait_done(1, 3, 0, 1, 0, 32'h0, "w3_store");
    issue(1, 1, 0, 32'h24, 32'h0BADCAFE, 4'hF);
    wait_done(1, 3, 0, 1, 0, 32'h0, "w3_store2");
    issue(1, 0, 1, 32'h20, 32'h0, 4'hF);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("w3_ld_c%0d_ready", k), 32'(rdy[1]), 32'd0);
      chk($sformatf("w3_ld_c%0d_done", k), 32'(ldone[1]), 32'd0);
      @(negedge clk);
      ld[1] = 1'b1; addr[1] = 32'h24;
      @(posedge clk); #1;
    end
    chk("w3_ld_done", 32'(ldone[1]), 32'd1);
    chk("w3_ld_data", rdata[1], 32'h600DF00D);
    chk("w3_ld_ready", 32'(rdy[1]), 32'd1);
    @(negedge clk);
    clear(1);
    @(posedge clk); #1;
    chk("w3_ld_after_done", 32'(ldone[1]), 32'd0);
    chk("w3_ld_after_ready", 32'(rdy[1]), 32'd1);
    chk("w3_ld_after_data", rdata[1], 32'h600DF00D);

    // W=2: reset mid-wait aborts the store
    issue(2, 1, 0, 32'h40, 32'h01020304, 4'hF);
    wait_done(2, 2, 0, 1, 0, 32'h0, "w2_store");
    issue(2, 1, 0, 32'h40, 32'hFFFFFFFF, 4'hF);
    chk("w2_abort_busy", 32'(rdy[2]), 32'd0);
    @(negedge clk);
    clear(2);
    rst[2] = 1'b1;
    #1;
    chk("w2_abort_ready", 32'(rdy[2]), 32'd1);
    chk("w2_abort_done", 32'(sdone[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("w2_post_rst%0d_done", k), 32'({ldone[2], sdone[2]}), 32'd0);
      chk($sformatf("w2_post_rst%0d_ready", k), 32'(rdy[2]), 32'd1);
    end
    issue(2, 0, 1, 32'h40, 32'h0, 4'hF);
    wait_done(2, 2, 1, 0, 0, 32'h01020304, "w2_load_old");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
